// File: rtl/wtm_pipe_mult_if.sv
// Operand/product handshake bundle for the pipelined Wallace-tree multiplier.
// The master side produces operands and consumes products; the slave side is the multiplier.
interface wtm_pipe_mult_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/wtm_pipe_mult.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per transaction,
// with a globally stalled valid/ready pipeline of 1..3 register stages.
module wtm_pipe_mult #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic           clk,
    input  logic           rst,
    wtm_pipe_mult_if.slave bus_io
);
    localparam int NCOL    = 2 * WIDTH;
    localparam int MAXH    = WIDTH + 2;
    localparam int NLAYERS = 10;

    typedef logic [WIDTH-1:0][WIDTH-1:0] ppMatrix_t;

    typedef struct packed {
        logic [NCOL-1:0] sumRow;
        logic [NCOL-1:0] carryRow;
    } redRows_t;

    if (WIDTH < 4 || WIDTH > 32) begin : gWidthCheck
        $error("wtm_pipe_mult: WIDTH must lie in 4..32");
    end
    if (STAGES < 1 || STAGES > 3) begin : gStagesCheck
        $error("wtm_pipe_mult: STAGES must lie in 1..3");
    end

    // Row i holds a[j]&b[i] at weight i+j; in signed mode the MSB row and column
    // are inverted except the a[MSB]&b[MSB] corner (Baugh-Wooley).
    function automatic ppMatrix_t genPartials(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sgn
    );
        ppMatrix_t rows;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                rows[i][j] = (x[j] & y[i]) ^ (sgn & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
            end
        end
        return rows;
    endfunction

    // Column-wise Wallace reduction: every layer compresses each column taller than two
    // with full adders, a half adder on a leftover pair, and passes a single leftover bit.
    // Layers past convergence are pass-throughs, so a fixed layer count covers every WIDTH.
    function automatic redRows_t wallaceReduce(
        input ppMatrix_t rows,
        input logic      corr
    );
        logic [MAXH-1:0] colBits [NCOL];
        logic [MAXH-1:0] nxtBits [NCOL];
        int              colCnt  [NCOL];
        int              nxtCnt  [NCOL];
        int              used;
        logic            x0, x1, x2;
        redRows_t        res;

        for (int c = 0; c < NCOL; c++) begin
            colBits[c] = '0;
            colCnt[c]  = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                colBits[i+j][colCnt[i+j]] = rows[i][j];
                colCnt[i+j]++;
            end
        end
        colBits[WIDTH][colCnt[WIDTH]] = corr;
        colCnt[WIDTH]++;
        colBits[NCOL-1][colCnt[NCOL-1]] = corr;
        colCnt[NCOL-1]++;

        for (int layer = 0; layer < NLAYERS; layer++) begin
            for (int c = 0; c < NCOL; c++) begin
                nxtBits[c] = '0;
                nxtCnt[c]  = 0;
            end
            for (int c = 0; c < NCOL; c++) begin
                used = 0;
                if (colCnt[c] > 2) begin
                    for (int k = 0; k < MAXH / 3; k++) begin
                        if (3 * k + 2 < colCnt[c]) begin
                            x0 = colBits[c][3*k];
                            x1 = colBits[c][3*k+1];
                            x2 = colBits[c][3*k+2];
                            nxtBits[c][nxtCnt[c]] = x0 ^ x1 ^ x2;
                            nxtCnt[c]++;
                            if (c + 1 < NCOL) begin
                                nxtBits[c+1][nxtCnt[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                                nxtCnt[c+1]++;
                            end
                            used = 3 * k + 3;
                        end
                    end
                    if (colCnt[c] - used == 2) begin
                        x0 = colBits[c][used];
                        x1 = colBits[c][used+1];
                        nxtBits[c][nxtCnt[c]] = x0 ^ x1;
                        nxtCnt[c]++;
                        if (c + 1 < NCOL) begin
                            nxtBits[c+1][nxtCnt[c+1]] = x0 & x1;
                            nxtCnt[c+1]++;
                        end
                        used = used + 2;
                    end
                end
                for (int k = 0; k < MAXH; k++) begin
                    if (k >= used && k < colCnt[c]) begin
                        nxtBits[c][nxtCnt[c]] = colBits[c][k];
                        nxtCnt[c]++;
                    end
                end
            end
            colBits = nxtBits;
            colCnt  = nxtCnt;
        end

        for (int c = 0; c < NCOL; c++) begin
            res.sumRow[c]   = colBits[c][0];
            res.carryRow[c] = colBits[c][1];
        end
        return res;
    endfunction

    logic            adv;
    logic            outValid_q;
    logic [NCOL-1:0] p_q;
    logic [NCOL-1:0] prod_d;

    // A full output register that nobody takes freezes every stage at once.
    assign adv             = bus_io.out_ready | ~outValid_q;
    assign bus_io.in_ready = adv;

    ppMatrix_t ppStage;
    logic      corrStage;
    logic      validPp;

    if (STAGES == 3) begin : gPpReg
        ppMatrix_t pp_q;
        logic      corr_q;
        logic      valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pp_q    <= '0;
                corr_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (adv) begin
                pp_q    <= genPartials(bus_io.a, bus_io.b, bus_io.is_signed);
                corr_q  <= bus_io.is_signed;
                valid_q <= bus_io.in_valid;
            end
        end

        assign ppStage   = pp_q;
        assign corrStage = corr_q;
        assign validPp   = valid_q;
    end else begin : gPpComb
        assign ppStage   = genPartials(bus_io.a, bus_io.b, bus_io.is_signed);
        assign corrStage = bus_io.is_signed;
        assign validPp   = bus_io.in_valid;
    end

    redRows_t redStage;
    logic     validRed;

    if (STAGES >= 2) begin : gRedReg
        redRows_t red_q;
        logic     valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                red_q   <= '0;
                valid_q <= 1'b0;
            end else if (adv) begin
                red_q   <= wallaceReduce(ppStage, corrStage);
                valid_q <= validPp;
            end
        end

        assign redStage = red_q;
        assign validRed = valid_q;
    end else begin : gRedComb
        assign redStage = wallaceReduce(ppStage, corrStage);
        assign validRed = validPp;
    end

    // Carry-propagate adder; the carry out of the top bit is dropped (exact mod 2^NCOL).
    assign prod_d = redStage.sumRow + redStage.carryRow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q        <= '0;
            outValid_q <= 1'b0;
        end else if (adv) begin
            p_q        <= prod_d;
            outValid_q <= validRed;
        end
    end

    assign bus_io.out_valid = outValid_q;
    assign bus_io.p         = p_q;
endmodule

// File: tb/tb_wtm_pipe_mult.sv
// Bench for wtm_pipe_mult: a cycle-level model on an 8-bit/3-stage instance, plus
// scoreboarded streams on a 4-bit/1-stage (exhaustive) and a 16-bit/2-stage instance.
module tb_wtm_pipe_mult;
    localparam int S8 = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wtm_pipe_mult_if #(.WIDTH(8))  bus8  ();
    wtm_pipe_mult_if #(.WIDTH(4))  bus4  ();
    wtm_pipe_mult_if #(.WIDTH(16)) bus16 ();

    wtm_pipe_mult #(.WIDTH(8),  .STAGES(3)) dut8  (.clk(clk), .rst(rst), .bus_io(bus8));
    wtm_pipe_mult #(.WIDTH(4),  .STAGES(1)) dut4  (.clk(clk), .rst(rst), .bus_io(bus4));
    wtm_pipe_mult #(.WIDTH(16), .STAGES(2)) dut16 (.clk(clk), .rst(rst), .bus_io(bus16));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    int     vecCount  = 0;
    int     missCount = 0;
    int     xferCount = 0;
    int     outCount  = 0;
    logic   mdlV [S8];
    longint mdlP [S8];

    // Reference product straight from the arithmetic definition of each mode.
    function automatic longint refMul(input longint x, input longint y, input logic sgn, input int w);
        longint xs;
        longint ys;
        longint mask;
        xs   = x;
        ys   = y;
        mask = (longint'(1) << (2 * w)) - 1;
        if (sgn && x[w-1]) xs = x - (longint'(1) << w);
        if (sgn && y[w-1]) ys = y - (longint'(1) << w);
        return (xs * ys) & mask;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle on the 8-bit instance: drive, check in_ready, advance the model, check outputs.
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input logic ordy, input longint expP);
        logic advExp;
        bus8.in_valid  = v;
        bus8.a         = a;
        bus8.b         = b;
        bus8.is_signed = s;
        bus8.out_ready = ordy;
        advExp = ordy || !mdlV[S8-1];
        #1;
        checkOutput("in_ready", {63'd0, bus8.in_ready}, {63'd0, advExp});
        if (bus8.out_valid && ordy) outCount++;
        @(posedge clk);
        if (advExp) begin
            for (int i = S8 - 1; i > 0; i--) begin
                mdlV[i] = mdlV[i-1];
                mdlP[i] = mdlP[i-1];
            end
            mdlV[0] = v;
            mdlP[0] = expP;
            if (v) xferCount++;
        end
        #1;
        checkOutput("out_valid", {63'd0, bus8.out_valid}, {63'd0, mdlV[S8-1]});
        if (mdlV[S8-1]) checkOutput("p", {48'd0, bus8.p}, mdlP[S8-1]);
    endtask

    task automatic randomStep(input int validPct, input int readyPct);
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        ra = 8'($urandom);
        rb = 8'($urandom);
        rs = 1'($urandom);
        applyStimulus($urandom_range(0, 99) < validPct, ra, rb, rs,
                      $urandom_range(0, 99) < readyPct, refMul(ra, rb, rs, 8));
    endtask

    task automatic doReset();
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", {63'd0, bus8.out_valid}, 64'd0);
        checkOutput("rst_p", {48'd0, bus8.p}, 64'd0);
        for (int i = 0; i < S8; i++) begin
            mdlV[i] = 1'b0;
            mdlP[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", {63'd0, bus8.in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Every operand pair in both modes, with the consumer randomly stalling.
    task automatic runW4();
        longint q[$];
        int     idx    = 0;
        int     budget = 0;
        logic [3:0] ta;
        logic [3:0] tb;
        logic       ts;
        while ((idx < 512 || q.size() > 0) && budget < 5000) begin
            ta = idx[3:0];
            tb = idx[7:4];
            ts = idx[8];
            bus4.in_valid  = (idx < 512);
            bus4.a         = ta;
            bus4.b         = tb;
            bus4.is_signed = ts;
            bus4.out_ready = (idx >= 512) || ($urandom_range(0, 3) != 0);
            #1;
            if (bus4.out_valid && bus4.out_ready) begin
                checkOutput("w4_pending", {63'd0, q.size() > 0}, 64'd1);
                if (q.size() > 0) checkOutput("w4_p", {56'd0, bus4.p}, q.pop_front());
            end
            if (bus4.in_valid && bus4.in_ready) begin
                q.push_back(refMul(ta, tb, ts, 4));
                idx++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        bus4.in_valid = 1'b0;
        checkOutput("w4_done", {63'd0, budget < 5000}, 64'd1);
    endtask

    task automatic runW16(input int total);
        longint q[$];
        int     sent   = 0;
        int     budget = 0;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        while ((sent < total || q.size() > 0) && budget < 20000) begin
            bus16.in_valid  = (sent < total) && ($urandom_range(0, 3) != 0);
            bus16.a         = ra;
            bus16.b         = rb;
            bus16.is_signed = rs;
            bus16.out_ready = (sent >= total) || ($urandom_range(0, 2) != 0);
            #1;
            if (bus16.out_valid && bus16.out_ready) begin
                checkOutput("w16_pending", {63'd0, q.size() > 0}, 64'd1);
                if (q.size() > 0) checkOutput("w16_p", {32'd0, bus16.p}, q.pop_front());
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q.push_back(refMul(ra, rb, rs, 16));
                sent++;
                ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                rs = 1'($urandom);
            end
            @(posedge clk);
            #1;
            budget++;
        end
        bus16.in_valid = 1'b0;
        checkOutput("w16_done", {63'd0, budget < 20000}, 64'd1);
    endtask

    initial begin
        vec_t vecs [9];
        vecs[0] = '{a: 8'd13,  b: 8'd11,  s: 1'b0, p: 16'd143};
        vecs[1] = '{a: 8'h80,  b: 8'h80,  s: 1'b1, p: 16'h4000};
        vecs[2] = '{a: 8'h80,  b: 8'h7F,  s: 1'b1, p: 16'hC080};
        vecs[3] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b1, p: 16'h0001};
        vecs[4] = '{a: 8'h7F,  b: 8'h7F,  s: 1'b1, p: 16'd16129};
        vecs[5] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b0, p: 16'hFE01};
        vecs[6] = '{a: 8'hFF,  b: 8'hFF,  s: 1'b1, p: 16'h0001};
        vecs[7] = '{a: 8'h80,  b: 8'h7F,  s: 1'b0, p: 16'h3F80};
        vecs[8] = '{a: 8'h00,  b: 8'hFF,  s: 1'b1, p: 16'h0000};

        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.is_signed  = 1'b0;
        bus8.out_ready  = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.a          = '0;
        bus4.b          = '0;
        bus4.is_signed  = 1'b0;
        bus4.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.is_signed = 1'b0;
        bus16.out_ready = 1'b1;

        doReset();

        $display("[TB] directed corner table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, longint'(vecs[i].p));
        end
        repeat (S8 + 1) applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 0);

        $display("[TB] reset with products in flight");
        repeat (3) randomStep(100, 100);
        doReset();
        applyStimulus(1'b1, 8'd13, 8'd11, 1'b0, 1'b1, 143);
        repeat (S8 + 1) applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 0);

        $display("[TB] backpressure and random streaming");
        xferCount = 0;
        outCount  = 0;
        repeat (6) randomStep(100, 100);
        repeat (5) randomStep(100, 0);
        repeat (300) randomStep(70, 60);
        repeat (S8 + 2) applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 0);
        checkOutput("product_count", 64'(outCount), 64'(xferCount));

        $display("[TB] exhaustive 4-bit, single stage");
        runW4();

        $display("[TB] random 16-bit, two stages");
        runW16(400);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/wtm_pipe_mult.md
Name: wtm_pipe_mult

Overview:
Parametrised, pipelined Wallace-tree multiplier and the successor to the 4-bit combinational Wallace tree multiplier. It generalises operand width, supports signed (Baugh-Wooley) and unsigned modes per transaction, and registers the datapath with a valid/ready handshake. It sits between operand producers and accumulator/MAC consumers that may apply backpressure.

Parameters:
WIDTH, 8, operand width in bits. Legal range 4..32.
STAGES, 3, pipeline depth and operand-to-result latency. Legal range 1..3. 1: register after the final adder only. 2: registers after the Wallace reduction and after the final adder. 3: registers after partial-product generation, after the reduction, and after the final adder.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands a, b and is_signed are valid this cycle
in_ready  out  1  block accepts an operand pair this cycle
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
is_signed  in  1  1: two's-complement operands; 0: unsigned operands
out_valid  out  1  p holds a valid product
out_ready  in  1  consumer accepts p this cycle
p  out  2*WIDTH  product, full width, no truncation

Behaviour:
- Reset: one clock, asynchronous and active-high. While rst=1, every stage valid bit, out_valid and p are forced to 0 immediately. in_ready reads 1 as soon as rst falls.
- Reset mid-operation: all in-flight products are discarded. No stale product appears after reset is released.
- Advance condition: adv = out_ready OR NOT out_valid. When adv=1, every stage shifts one place. When adv=0, every stage register, every valid bit and p hold their values (global stall).
- in_ready = adv, combinationally. A transfer occurs when in_valid AND in_ready.
- Latency: a transfer in cycle N produces out_valid=1 with its product in cycle N+STAGES, provided adv held in every intervening cycle.
- Throughput: one product per cycle while out_ready=1.
- Bubbles: bubbles are not collapsed. An invalid stage advances as a bubble. adv is 1 whenever out_valid=0, so bubbles never block input.
- Ordering: results leave in strict input order.
- Output stability: while out_valid=1 and out_ready=0, p and out_valid stay stable. The product is not lost or duplicated.
- is_signed travels with its operands. Mode changes between consecutive transactions are legal and take effect per transaction.
- Unsigned arithmetic: p = a*b, range 0..(2^WIDTH-1)^2.
- Signed arithmetic: Baugh-Wooley partial products, with the MSB partial-product row and column inverted and correction constants added at bits WIDTH and 2*WIDTH-1. p is the 2*WIDTH two's-complement product.
- Signed edge case: (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2). This fits in p without overflow.
- Reduction structure: WIDTH rows of WIDTH partial-product bits are reduced by a Wallace tree of full and half adders to two rows. A ripple or prefix carry-propagate adder then produces p. Carries beyond bit 2*WIDTH-1 are dropped; this is exact modulo 2^(2*WIDTH).
- Simultaneous input transfer and output consumption in the same cycle is legal. Both complete.
- Out-of-contract inputs: a, b and is_signed are don't-care when in_valid=0. Outputs are undefined for illegal parameter values; elaboration errors via a generate-time check.

Test Plan:
- Reset and latency: WIDTH=8, STAGES=3. Assert rst mid-stream with 3 products in flight, release, then send a=8'd13, b=8'd11, is_signed=0 -> out_valid rises exactly 3 cycles after the transfer with p=16'd143. No product issued before reset appears.
- Signed corners: WIDTH=8. Send (-128,-128), (-128,127), (-1,-1), (127,127) with is_signed=1 -> p = 16384, -16256 (0xC080), 1, 16129, in order.
- Unsigned max and mode switch: alternate a=b=8'hFF with is_signed=0, then is_signed=1, back to back -> p = 16'hFE01, then 16'h0001.
- Backpressure: streaming random operands, hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0 and p stable throughout. After release, every result matches the a*b reference with no loss or duplication, and the count of products equals the count of transfers.
- Parameter sweep: WIDTH in {4,8,16} and STAGES in {1,2,3}. 1000 random transactions per configuration with random in_valid/out_ready -> all products match the reference model. Latency equals STAGES when unstalled.
- Exhaustive 4-bit: WIDTH=4, all 256 operand pairs in both modes -> every p matches the reference, e.g. 4'd15*4'd15=8'd225 unsigned, and 4'hF*4'hF=8'd1 signed.
